// File: rtl/lift_pkg.sv
// Shared lift definitions: floor encoding, door sequencer states,
// hall-call bit positions and the floor-to-call ownership map.
// Used by lift_call_panel and the lift controller.
package lift_pkg;

    typedef enum logic [1:0] {
        FLOOR_G    = 2'd0,
        FLOOR_1    = 2'd1,
        FLOOR_2    = 2'd2,
        FLOOR_NONE = 2'd3
    } floor_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } door_st_t;

    localparam int CALL_G_UP = 0;
    localparam int CALL_F_UP = 1;
    localparam int CALL_F_DN = 2;
    localparam int CALL_S_DN = 3;

    // Calls served by a stop at floor f. The first floor serves both
    // directions together; between floors nothing is served.
    function automatic logic [3:0] calls_owned(input floor_t f);
        logic [3:0] m;
        m = '0;
        case (f)
            FLOOR_G: m[CALL_G_UP] = 1'b1;
            FLOOR_1: begin
                m[CALL_F_UP] = 1'b1;
                m[CALL_F_DN] = 1'b1;
            end
            FLOOR_2: m[CALL_S_DN] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lift_door_timer.sv
// Door dwell down-counter.
//   clk, reset : clock, async active-high reset
//   load       : reload count to DOOR_CYCLES-1 (wins over dec)
//   dec        : decrement, holding at zero
//   zero       : terminal count reached
module lift_door_timer #(
    parameter int DOOR_CYCLES = 4,
    parameter int CNT_W       = $clog2(DOOR_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(DOOR_CYCLES - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lift_call_panel.sv
// Hall-call front end for the 3-floor lift controller.
// Latches hall buttons, presents calls to the controller, clears calls
// when the car stops at their floor and runs the door-open dwell.
//   clk, reset         : clock, async active-high reset
//   btn_g_up .. s_dn   : hall buttons (synchronous levels)
//   car_floor          : car position from controller (3 = between floors)
//   req_g/req_f/req_s  : call requests to controller, gated off unless IDLE
//   door_open          : door open command
//   pending            : latched calls {s_dn, f_dn, f_up, g_up}
//
// state | meaning
// IDLE  | door closed, calls presented, waiting for a call at floor_q
// OPEN  | door open, dwell counting down, same-floor press restarts dwell
// CLOSE | one closed cycle before calls are presented again
module lift_call_panel
    import lift_pkg::*;
#(
    parameter  int DOOR_CYCLES = 4,
    localparam int CNT_W       = $clog2(DOOR_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_g_up,
    input  logic       btn_f_up,
    input  logic       btn_f_dn,
    input  logic       btn_s_dn,
    input  logic [1:0] car_floor,
    output logic       req_g,
    output logic [1:0] req_f,
    output logic       req_s,
    output logic       door_open,
    output logic [3:0] pending
);

    logic [3:0] btn;
    logic [3:0] btn_q;
    logic [3:0] press;
    logic [3:0] own;
    logic [3:0] pending_q;
    logic [3:0] pending_d;
    floor_t     floor_q;
    door_st_t   state_q;
    door_st_t   state_d;
    logic       door_open_q;
    logic       door_open_d;
    logic       reopen;
    logic       tmr_load;
    logic       tmr_dec;
    logic       tmr_zero;

    assign btn    = {btn_s_dn, btn_f_dn, btn_f_up, btn_g_up};
    assign press  = btn & ~btn_q;
    assign own    = calls_owned(floor_q);
    assign reopen = |(press & own);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | press;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|(pending_q & own)) begin
                    state_d   = OPEN;
                    // Same-floor press on this edge is absorbed by the service.
                    pending_d = (pending_q | press) & ~own;
                    tmr_load  = 1'b1;
                end
            end
            OPEN: begin
                pending_d = pending_q | (press & ~own);
                if (reopen) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    state_d = CLOSE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CLOSE: begin
                pending_d = pending_q | (press & ~own);
                if (reopen) begin
                    state_d  = OPEN;
                    tmr_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        door_open_d = (state_d == OPEN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            door_open_q <= 1'b0;
            pending_q   <= '0;
            btn_q       <= '0;
            floor_q     <= FLOOR_NONE;
        end else begin
            state_q     <= state_d;
            door_open_q <= door_open_d;
            pending_q   <= pending_d;
            btn_q       <= btn;
            floor_q     <= floor_t'(car_floor);
        end
    end

    lift_door_timer #(
        .DOOR_CYCLES (DOOR_CYCLES),
        .CNT_W       (CNT_W)
    ) u_door_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .zero  (tmr_zero)
    );

    // Requests come straight from flops; the controller never sees a call
    // while the door sequence is running.
    assign req_g     = (state_q == IDLE) & pending_q[CALL_G_UP];
    assign req_f     = (state_q == IDLE) ? {pending_q[CALL_F_UP], pending_q[CALL_F_DN]} : 2'b00;
    assign req_s     = (state_q == IDLE) & pending_q[CALL_S_DN];
    assign door_open = door_open_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_lift_call_panel.sv
module tb_lift_call_panel;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_g_up;
    logic       btn_f_up;
    logic       btn_f_dn;
    logic       btn_s_dn;
    logic [1:0] car_floor;
    logic       req_g;
    logic [1:0] req_f;
    logic       req_s;
    logic       door_open;
    logic [3:0] pending;

    lift_call_panel #(.DOOR_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_g_up  (btn_g_up),
        .btn_f_up  (btn_f_up),
        .btn_f_dn  (btn_f_dn),
        .btn_s_dn  (btn_s_dn),
        .car_floor (car_floor),
        .req_g     (req_g),
        .req_f     (req_f),
        .req_s     (req_s),
        .door_open (door_open),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] pend;
        logic       rg;
        logic [1:0] rf;
        logic       rs;
        logic       door;
    } snap_t;

    typedef struct {
        string name;
        int    len;
    } dwell_t;

    snap_t  snap_q[$];
    dwell_t dwell_q[$];
    int     checks = 0;
    int     errors = 0;
    int     run_len = 0;
    logic   end_req = 1'b0;
    logic   end_done = 1'b0;

    task automatic expect_snap(input string n, input logic [3:0] p, input logic rg,
                               input logic [1:0] rf, input logic rs, input logic d);
        snap_t s;
        s.name = n;
        s.pend = p;
        s.rg   = rg;
        s.rf   = rf;
        s.rs   = rs;
        s.door = d;
        snap_q.push_back(s);
    endtask

    task automatic expect_dwell(input string n, input int len);
        dwell_t d;
        d.name = n;
        d.len  = len;
        dwell_q.push_back(d);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: state snapshots, dwell lengths, and request gating while open.
    always @(negedge clk) begin
        snap_t  s;
        dwell_t d;
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            checks++;
            if ({pending, req_g, req_f, req_s, door_open} !== {s.pend, s.rg, s.rf, s.rs, s.door}) begin
                errors++;
                $display("FAIL %s: got pending=%b req_g=%b req_f=%b req_s=%b door_open=%b, want pending=%b req_g=%b req_f=%b req_s=%b door_open=%b",
                         s.name, pending, req_g, req_f, req_s, door_open,
                         s.pend, s.rg, s.rf, s.rs, s.door);
            end
        end
        if (door_open === 1'b1) begin
            run_len++;
            checks++;
            if ({req_g, req_f, req_s} !== 4'b0000) begin
                errors++;
                $display("FAIL req_gated: got req_g=%b req_f=%b req_s=%b while door open, want all 0",
                         req_g, req_f, req_s);
            end
        end else if (run_len > 0) begin
            checks++;
            if (dwell_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dwell: got door_open run of %0d cycles, want none", run_len);
            end else begin
                d = dwell_q.pop_front();
                if (run_len != d.len) begin
                    errors++;
                    $display("FAIL dwell_%s: got %0d cycles, want %0d", d.name, run_len, d.len);
                end
            end
            run_len = 0;
        end
        if (end_req && !end_done) begin
            checks++;
            if (dwell_q.size() != 0) begin
                errors++;
                $display("FAIL dwell_missing: got %0d door runs outstanding, want 0", dwell_q.size());
            end
            end_done = 1'b1;
        end
    end

    initial begin
        reset     = 1'b1;
        btn_g_up  = 1'b0;
        btn_f_up  = 1'b1;
        btn_f_dn  = 1'b0;
        btn_s_dn  = 1'b0;
        car_floor = 2'd0;
        tick(2);
        expect_snap("reset_state", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);

        // 1: button held through reset counts as one press
        reset = 1'b0;
        tick(1);
        expect_snap("t1_held_press", 4'b0010, 1'b0, 2'b10, 1'b0, 1'b0);
        btn_f_up = 1'b0;

        // 2: ground call with car at ground
        btn_g_up = 1'b1;
        tick(1);
        expect_snap("t2_latched", 4'b0011, 1'b1, 2'b10, 1'b0, 1'b0);
        btn_g_up = 1'b0;
        expect_dwell("t2", 4);
        tick(1);
        expect_snap("t2_open", 4'b0010, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(7);
        expect_snap("t2_idle", 4'b0010, 1'b0, 2'b10, 1'b0, 1'b0);

        // 3: second-floor call served after car arrives
        btn_s_dn = 1'b1;
        tick(1);
        expect_snap("t3_latched", 4'b1010, 1'b0, 2'b10, 1'b1, 1'b0);
        btn_s_dn = 1'b0;
        tick(3);
        expect_snap("t3_held", 4'b1010, 1'b0, 2'b10, 1'b1, 1'b0);
        car_floor = 2'd2;
        tick(1);
        expect_snap("t3_floor_reg", 4'b1010, 1'b0, 2'b10, 1'b1, 1'b0);
        expect_dwell("t3", 4);
        tick(1);
        expect_snap("t3_open", 4'b0010, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(7);
        expect_snap("t3_idle", 4'b0010, 1'b0, 2'b10, 1'b0, 1'b0);

        // 4: reopen on 2nd dwell cycle at first floor
        car_floor = 2'd1;
        tick(1);
        expect_snap("t4_floor_reg", 4'b0010, 1'b0, 2'b10, 1'b0, 1'b0);
        expect_dwell("t4", 6);
        tick(1);
        expect_snap("t4_open", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(1);
        btn_f_dn = 1'b1;
        tick(1);
        btn_f_dn = 1'b0;
        expect_snap("t4_reopen", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(6);
        expect_snap("t4_idle", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);

        // 5: between floors, all buttons held
        car_floor = 2'd3;
        tick(1);
        {btn_s_dn, btn_f_dn, btn_f_up, btn_g_up} = 4'b1111;
        tick(1);
        expect_snap("t5_latched", 4'b1111, 1'b1, 2'b11, 1'b1, 1'b0);
        tick(4);
        expect_snap("t5_held", 4'b1111, 1'b1, 2'b11, 1'b1, 1'b0);
        {btn_s_dn, btn_f_dn, btn_f_up, btn_g_up} = 4'b0000;
        tick(1);

        // 6: reset mid-dwell, then normal service afterwards
        car_floor = 2'd0;
        tick(1);
        expect_dwell("t6_cut", 1);
        tick(1);
        expect_snap("t6_open", 4'b1110, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(1);
        #2;
        reset = 1'b1;
        expect_snap("t6_reset", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(1);
        reset = 1'b0;
        expect_snap("t6_released", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(1);
        btn_g_up = 1'b1;
        tick(1);
        expect_snap("t6_latched", 4'b0001, 1'b1, 2'b00, 1'b0, 1'b0);
        btn_g_up = 1'b0;
        expect_dwell("t6_after", 4);
        tick(1);
        expect_snap("t6_serve", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1);
        tick(7);
        expect_snap("t6_idle", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);

        tick(3);
        end_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
